// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter
//
// Sends one byte from the host to a PS/2 device. The sequence is: inhibit
// the clock, request-to-send with a start bit, 8 data bits LSB first, odd
// parity, stop bit, then check the device ACK. Pads are open collector:
// an oe of 1 drives the line low, and an oe of 0 releases it.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   tx_data/tx_valid  byte request, accepted only while tx_ready is high
//   tx_ready          idle, a byte can be accepted
//   ps2_clk_in        raw PS2_CLK pad level
//   ps2_data_in       raw PS2_DATA pad level
//   ps2_clk_oe        registered pull-down enable for PS2_CLK
//   ps2_data_oe       registered pull-down enable for PS2_DATA
//   busy              lines in host-to-device use (gates the receiver)
//   tx_done           one-cycle pulse, byte acknowledged
//   tx_err            one-cycle pulse, NACK or timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  // One counter serves both the inhibit phase and the transfer timeout;
  // the two phases never overlap.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_last_q;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            clk_s;
  logic            data_s;
  logic            fall;
  logic            timed_out;

  assign clk_s     = clk_sync_q[1];
  assign data_s    = data_sync_q[1];
  assign fall      = clk_last_q & ~clk_s;
  assign timed_out = (cnt_q == TMO_LAST);

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

  // Synchronizers reset to 1 (idle bus level) so reset release cannot
  // fabricate a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_last_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_last_q  <= clk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= 8'h00;
      parity_q  <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= 4'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // The oe values computed here are those for the state being entered, so
  // the registered pad enables line up with the state register.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          data_d    = tx_data;
          parity_d  = ~^tx_data;
          cnt_d     = '0;
          bit_idx_d = 4'd0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RTS: begin
        // Release the clock while still holding the start bit.
        cnt_d     = '0;
        bit_idx_d = 4'd0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        state_d   = S_SEND;
      end

      S_SEND: begin
        cnt_d    = cnt_q + CW'(1);
        clk_oe_d = 1'b0;
        if (timed_out) begin
          err_d     = 1'b1;
          data_oe_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (fall) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd8) begin
            data_oe_d = ~data_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end
      end

      S_ACK: begin
        cnt_d     = cnt_q + CW'(1);
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (timed_out) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (fall) begin
          if (data_s) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        cnt_d     = cnt_q + CW'(1);
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (timed_out) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (clk_s && data_s) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clk cycles PS/2 clock is held low before request-to-send (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, max clk cycles from request-to-send to ACK before abort (20 ms).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named as the codebase names them:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
REQ-004 SHALL have the remaining ports:
- tx_data, input, 8: command/data byte to send to the device.
- tx_valid, input, 1: byte request.
- tx_ready, output, 1: block idle, can accept a byte.
- ps2_clk_in, input, 1: raw PS2_CLK pad level.
- ps2_data_in, input, 1: raw PS2_DATA pad level.
- ps2_clk_oe, output, 1: 1 = drive PS2_CLK low, 0 = release (open collector).
- ps2_data_oe, output, 1: 1 = drive PS2_DATA low, 0 = release.
- busy, output, 1: high while PS2_CLK/PS2_DATA are in host-to-device use; the receiver is gated with it.
- tx_done, output, 1: one-cycle pulse, byte acknowledged by the device.
- tx_err, output, 1: one-cycle pulse, timeout or missing ACK.

Function
REQ-005 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-006 SHALL implement states IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-007 IDLE: tx_ready=1, both oe=0, busy=0; on tx_valid&&tx_ready, latch tx_data and odd parity (~^tx_data), clear counters, go to INHIBIT next cycle.
REQ-008 SHALL ignore tx_valid whenever tx_ready=0; the latched byte is unaffected by tx_data changes after acceptance.
REQ-009 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-010 RTS: ps2_clk_oe=1, ps2_data_oe=1 for exactly 1 cycle (start bit); clear the timeout counter; go to SEND.
REQ-011 SEND: ps2_clk_oe=0; bit index starts at 0 and ps2_data_oe holds the start bit (1) until the first falling edge.
REQ-012 SEND falling-edge updates:
- Falling edges 1..8: ps2_data_oe = ~data[k-1], LSB first.
- Falling edge 9: ps2_data_oe = ~parity.
- Falling edge 10: ps2_data_oe = 0 (stop bit), then go to ACK.
REQ-013 ACK: on the next falling edge, sample synced data; 0 means ACK, go to WAIT_IDLE; 1 means pulse tx_err and go to IDLE.
REQ-014 WAIT_IDLE: when synced clock and data are both 1, pulse tx_done and go to IDLE.
REQ-015 The timeout counter SHALL count every cycle in SEND, ACK and WAIT_IDLE; when it reaches TIMEOUT_CYCLES it pulses tx_err, releases both lines the same cycle, and goes to IDLE.
REQ-016 tx_done and tx_err SHALL never be asserted in the same cycle and SHALL be registered.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 All oe outputs SHALL be registered (glitch-free at the pads).

Reset
REQ-019 rst asserted SHALL immediately force: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_err=0, tx_ready=1, and counters/shift register to 0, including mid-transfer.
REQ-020 After rst deasserts, the first accepted byte SHALL start a full INHIBIT phase; no partial frame resumes.

Verification (bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clocks at 40-cycle period)
REQ-021 Send 0xED with a device ACK:
- ps2_clk_oe high for 20 cycles, then the start bit.
- Data bits 1,0,1,1,0,1,1,1, then parity 1, then stop released.
- tx_done pulses once; tx_ready returns to 1.
REQ-022 Send 0x00 with a device NACK (data high at edge 11): parity bit 1, tx_err pulses once, no tx_done, both oe=0.
REQ-023 Device never clocks after RTS: tx_err pulses exactly 2000 cycles after SEND entry, and both lines are released.
REQ-024 Assert rst during data bit 4 of 0xF4: oe outputs drop to 0 asynchronously, before the next clk edge. A following send of 0xF4 completes with bits 0,0,1,0,1,1,1,1, parity 0.
REQ-025 Pulse tx_valid with 0x55 during the INHIBIT of 0xED: 0xED is sent unchanged, 0x55 is dropped, and tx_done pulses exactly once.
